// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on magnitudes, with sign fix-up in a final cycle.
module execute_muldiv #(
  parameter int WIDTH     = 32,
  parameter int STEP      = 1,
  parameter int ZERO_SKIP = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             kill_i,
  input  logic             hold_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int ITER = WIDTH / STEP;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;

  logic                 is_div, sign_a, sign_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH-1:0]     int_min;
  logic [2*WIDTH-1:0]   step_acc, prod;
  logic [WIDTH-1:0]     quot, rem;
  logic [WIDTH:0]       sum, trial, diff;

  assign int_min = {1'b1, {(WIDTH-1){1'b0}}};
  assign is_div  = op_i[2];
  assign sign_a  = a_i[WIDTH-1] & ((op_i == 3'd1) | (op_i == 3'd2) | (op_i == 3'd4) | (op_i == 3'd6));
  assign sign_b  = b_i[WIDTH-1] & ((op_i == 3'd1) | (op_i == 3'd4) | (op_i == 3'd6));
  assign mag_a   = sign_a ? -a_i : a_i;
  assign mag_b   = sign_b ? -b_i : b_i;

  // Multiply: low half holds the multiplier, shifted out LSB first.
  // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
  always_comb begin
    step_acc = acc_q;
    sum      = '0;
    trial    = '0;
    diff     = '0;
    for (int i = 0; i < STEP; i++) begin
      if (op_q[2]) begin
        trial = step_acc[2*WIDTH-1:WIDTH-1];
        diff  = trial - {1'b0, mcand_q};
        if (!diff[WIDTH]) step_acc = {diff[WIDTH-1:0], step_acc[WIDTH-2:0], 1'b1};
        else              step_acc = {trial[WIDTH-1:0], step_acc[WIDTH-2:0], 1'b0};
      end else begin
        sum      = {1'b0, step_acc[2*WIDTH-1:WIDTH]} + (step_acc[0] ? {1'b0, mcand_q} : '0);
        step_acc = {sum, step_acc[WIDTH-1:1]};
      end
    end
  end

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quot = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !kill_i) begin
          op_d      = op_i;
          neg_res_d = sign_a ^ sign_b;
          neg_rem_d = sign_a;
          cnt_d     = CW'(ITER);
          if (is_div && (b_i == '0)) begin
            result_d = op_i[1] ? a_i : '1;
            state_d  = S_DONE;
          end else if (is_div && !op_i[0] && (a_i == int_min) && (b_i == '1)) begin
            result_d = op_i[1] ? '0 : a_i;
            state_d  = S_DONE;
          end else if ((ZERO_SKIP != 0) && !is_div && ((a_i == '0) || (b_i == '0))) begin
            result_d = '0;
            state_d  = S_DONE;
          end else begin
            mcand_d = is_div ? mag_b : mag_a;
            acc_d   = is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!kill_i) begin
          case (op_q)
            3'd0:                result_d = prod[WIDTH-1:0];
            3'd1, 3'd2, 3'd3:    result_d = prod[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:          result_d = quot;
            default:             result_d = rem;
          endcase
        end
        state_d = S_DONE;
      end
      default: begin
        if (!hold_i) state_d = S_IDLE;
      end
    endcase
    if (kill_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign stall_o  = ((state_q == S_IDLE) && start_i && !kill_i) || (state_q == S_RUN) || (state_q == S_FIX);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;

endmodule
